prio_arbiter: RTL

Four-requester priority arbiter. Each cycle it picks the requester with the highest effective 2-bit priority, using the same max-of-two rule as the `max_sel` comparator tree, and holds the grant until that requester releases. Effective priority is the requester's own priority plus a saturating aging boost. Ties are broken round-robin. The block sits directly downstream of the comparator stage: it registers the winner and turns the combinational selection into a request/grant handshake.

---
 rtl/prio_arbiter_if.sv | 30 +++
 rtl/prio_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_if.sv
// prio_arbiter_if: request/grant bundle between requesters and prio_arbiter.
//   req       [3:0] : per-requester request, held while wanting or holding the bus
//   prio      [7:0] : prio[2i+1:2i] is requester i's base priority (0..3)
//   gnt       [3:0] : one-hot grant (registered in the arbiter)
//   gnt_valid       : OR of gnt
//   gnt_id    [1:0] : index of the granted requester, 0 when idle
// master = requester side, slave = arbiter side.
interface prio_arbiter_if;
    logic [3:0] req;
    logic [7:0] prio;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    modport master (
        output req,
        output prio,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        input  prio,
        output gnt,
        output gnt_valid,
        output gnt_id
    );
endinterface

// File: rtl/prio_arbiter.sv
// prio_arbiter: four-requester priority arbiter with aging and round-robin
// tie-breaking. The winner is registered and held until its requester drops
// req; one idle cycle always separates a release from the next grant.
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : prio_arbiter_if.slave (req/prio in, gnt/gnt_valid/gnt_id out)
// Parameter AGE_LIMIT: waiting edges per +1 aging boost (>= 2).
module prio_arbiter #(
    parameter int AGE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_arbiter_if.slave   bus
);
    localparam int CW = $clog2(AGE_LIMIT);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     gnt_reg, gnt_next;
    logic           gnt_valid_reg, gnt_valid_next;
    logic [1:0]     gnt_id_reg, gnt_id_next;
    logic [1:0]     rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]  wait_reg [4];
    logic [CW-1:0]  wait_next [4];
    logic [1:0]     boost_reg [4];
    logic [1:0]     boost_next [4];

    logic [1:0]     eff [4];
    logic [1:0]     meff [4];
    logic [1:0]     max01, max23, max_eff;
    logic [1:0]     win_id;
    logic [1:0]     scan_idx;
    logic           scan_hit;
    logic [3:0]     owner;

    // Effective priority: 3-bit sum of base priority and boost, saturated to 3.
    // Non-requesters are masked to 0 for the max tree; the scan below also
    // requires req, so a masked input can never win.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_eff
            logic [2:0] sum;
            assign sum       = {1'b0, bus.prio[2*gi+1:2*gi]} + {1'b0, boost_reg[gi]};
            assign eff[gi]   = sum[2] ? 2'd3 : sum[1:0];
            assign meff[gi]  = bus.req[gi] ? eff[gi] : 2'd0;
        end
    endgenerate

    // Max-of-two comparator tree over the masked effective priorities.
    assign max01   = (meff[0] >= meff[1]) ? meff[0] : meff[1];
    assign max23   = (meff[2] >= meff[3]) ? meff[2] : meff[3];
    assign max_eff = (max01 >= max23) ? max01 : max23;

    // Round-robin tie-break: first requester at max_eff scanning from rr_ptr.
    always_comb begin
        win_id   = rr_ptr_reg;
        scan_idx = rr_ptr_reg;
        scan_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_reg + 2'(k);
            if (!scan_hit && bus.req[scan_idx] && (eff[scan_idx] == max_eff)) begin
                win_id   = scan_idx;
                scan_hit = 1'b1;
            end
        end
    end

    // Next-state / output logic. owner marks the requester that is being
    // granted or is holding at this edge; its aging state is cleared.
    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        gnt_id_next    = gnt_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        owner          = 4'b0000;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    state_next     = GRANT;
                    gnt_next       = 4'b0001 << win_id;
                    gnt_valid_next = 1'b1;
                    gnt_id_next    = win_id;
                    owner[win_id]  = 1'b1;
                end
            end
            GRANT: begin
                if (bus.req[gnt_id_reg]) begin
                    owner[gnt_id_reg] = 1'b1;
                end else begin
                    // Release only; the next grant waits for the following edge.
                    state_next     = IDLE;
                    gnt_next       = 4'b0000;
                    gnt_valid_next = 1'b0;
                    gnt_id_next    = 2'd0;
                    rr_ptr_next    = gnt_id_reg + 2'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Aging: a waiting requester gains +1 boost every AGE_LIMIT edges,
    // saturating at 3; dropping req or owning the bus clears it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_age
            logic age_clear;
            logic age_wrap;
            assign age_clear      = ~bus.req[gi] | owner[gi];
            assign age_wrap       = (wait_reg[gi] == CW'(AGE_LIMIT - 1));
            assign wait_next[gi]  = (age_clear || age_wrap) ? '0 : wait_reg[gi] + CW'(1);
            assign boost_next[gi] = age_clear ? 2'd0 :
                                    (age_wrap && (boost_reg[gi] != 2'd3)) ? boost_reg[gi] + 2'd1 :
                                    boost_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= 4'b0000;
            gnt_valid_reg <= 1'b0;
            gnt_id_reg    <= 2'd0;
            rr_ptr_reg    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                wait_reg[i]  <= '0;
                boost_reg[i] <= 2'd0;
            end
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            gnt_id_reg    <= gnt_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            for (int i = 0; i < 4; i++) begin
                wait_reg[i]  <= wait_next[i];
                boost_reg[i] <= boost_next[i];
            end
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.gnt_id    = gnt_id_reg;

endmodule
